// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if: request/grant and VGA pixel bus between the box plotters
// and plot_arbiter.
//   master : requester side (drives req/req_x/req_y/req_colour, sees ack/done
//            and the VGA pixel outputs)
//   slave  : arbiter side (the reverse)
// Per-source fields are packed: source i occupies x[8i+7:8i], y[7i+6:7i],
// colour[3i+2:3i]. Source 0 = player, 1 = CPU, 2 = eraser.
interface plot_arbiter_if;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  modport master (
    output req, req_x, req_y, req_colour,
    input  ack, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, req_x, req_y, req_colour,
    output ack, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares one VGA pixel-write port among three box plotters
// (player, CPU, eraser). One request is granted at a time; the granted
// top-left corner is swept over a BOX_W x BOX_H pixel box, then done pulses.
//
// Ports:
//   clk     : system clock, rising edge
//   resetn  : synchronous active-low reset
//   bus     : plot_arbiter_if.slave (req/x/y/colour in; ack/done/busy and
//             vga_x/vga_y/vga_colour/vga_plot out, all registered)
//
// Build option:
//   PLOT_ARB_FIXED_PRIO_EN : fixed priority eraser > player > CPU.
//   Undefined (default)    : round-robin starting after the last grant.
module plot_arbiter #(
  parameter int BOX_W = 4,
  parameter int BOX_H = 2
) (
  input  logic          clk,
  input  logic          resetn,
  plot_arbiter_if.slave bus
);

  typedef enum logic {IDLE, DRAW} state_e;

  localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
  localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);

  state_e      state_q, state_d;
  logic [3:0]  cx_q, cx_d, cy_q, cy_d;
  logic [7:0]  bx_q, bx_d;
  logic [6:0]  by_q, by_d;
  logic [1:0]  g_q, g_d;
  logic [2:0]  ack_q, ack_d, done_q, done_d;
  logic        busy_q, busy_d;
  logic [7:0]  vx_q, vx_d;
  logic [6:0]  vy_q, vy_d;
  logic [2:0]  col_q, col_d;
  logic        plot_q, plot_d;

  logic [1:0]  gnt;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_col;

`ifdef PLOT_ARB_FIXED_PRIO_EN
  always_comb begin
    if (bus.req[2])      gnt = 2'd2;
    else if (bus.req[0]) gnt = 2'd0;
    else                 gnt = 2'd1;
  end
`else
  logic [1:0] last_q, last_d;

  // Search order starts one past the last granted source.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] o0, o1, o2;
    case (last)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (r[o0])      return o0;
    else if (r[o1]) return o1;
    else            return o2;
  endfunction

  always_comb gnt = rr_pick(bus.req, last_q);
`endif

  always_comb begin
    case (gnt)
      2'd1:    begin sel_x = bus.req_x[15:8];  sel_y = bus.req_y[13:7];  sel_col = bus.req_colour[5:3]; end
      2'd2:    begin sel_x = bus.req_x[23:16]; sel_y = bus.req_y[20:14]; sel_col = bus.req_colour[8:6]; end
      default: begin sel_x = bus.req_x[7:0];   sel_y = bus.req_y[6:0];   sel_col = bus.req_colour[2:0]; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    bx_d    = bx_q;
    by_d    = by_q;
    g_d     = g_q;
    ack_d   = '0;
    done_d  = '0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    col_d   = col_q;
    plot_d  = plot_q;
`ifndef PLOT_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req != 3'b000) begin
          g_d     = gnt;
          bx_d    = sel_x;
          by_d    = sel_y;
          col_d   = sel_col;
          cx_d    = '0;
          cy_d    = '0;
          ack_d   = 3'b001 << gnt;
          vx_d    = sel_x;
          vy_d    = sel_y;
          plot_d  = 1'b1;
          state_d = DRAW;
`ifndef PLOT_ARB_FIXED_PRIO_EN
          last_d  = gnt;
`endif
        end
      end
      DRAW: begin
        if (cx_q == CX_LAST && cy_q == CY_LAST) begin
          // Last pixel has had its cycle on the bus.
          plot_d  = 1'b0;
          done_d  = 3'b001 << g_q;
          state_d = IDLE;
        end else begin
          if (cx_q == CX_LAST) begin
            cx_d = '0;
            cy_d = cy_q + 4'd1;
          end else begin
            cx_d = cx_q + 4'd1;
          end
          // Coordinates wrap naturally at 256 / 128; no clipping.
          vx_d = bx_q + {4'd0, cx_d};
          vy_d = by_q + {3'd0, cy_d};
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRAW);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      g_q     <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
`ifndef PLOT_ARB_FIXED_PRIO_EN
      last_q  <= 2'd2;
`endif
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      g_q     <= g_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
`ifndef PLOT_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.ack        = ack_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.vga_x      = vx_q;
  assign bus.vga_y      = vy_q;
  assign bus.vga_colour = col_q;
  assign bus.vga_plot   = plot_q;

endmodule
